// File: rtl/mono_pkg.sv
// Shared types and default configuration for the MONOPIX column-drain readout sequencer.
package mono_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DLY_FREEZE,
    READ_LO,
    READ_HI,
    UNFREEZE,
    HOLDOFF
  } state_t;

  // Power-on values the register block loads into the CONF_* fields.
  localparam int unsigned DEF_FREEZE_START = 2;
  localparam int unsigned DEF_READ_HIGH    = 1;
  localparam int unsigned DEF_READ_LOW     = 3;
  localparam int unsigned DEF_FREEZE_STOP  = 4;
  localparam int unsigned DEF_HOLDOFF      = 5;

endpackage

// File: rtl/mono_readout_seq_sync.sv
// Multi-stage flop synchroniser bringing a single asynchronous level into the CLK domain.
module mono_readout_seq_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST_B,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/mono_readout_seq.sv
// MONOPIX readout sequencer: freezes the matrix on token, strobes READ once per hit
// (throttled by FIFO back-pressure), then unfreezes and holds off before the next frame.
module mono_readout_seq
  import mono_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int HIT_CNT_W   = 16,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST_B,
  input  logic                   EN,
  input  logic                   TOKEN,
  input  logic                   FIFO_NEAR_FULL,
  input  logic                   CLR_CNT,
  input  logic [CNT_W-1:0]       CONF_FREEZE_START,
  input  logic [CNT_W-1:0]       CONF_READ_HIGH,
  input  logic [CNT_W-1:0]       CONF_READ_LOW,
  input  logic [CNT_W-1:0]       CONF_FREEZE_STOP,
  input  logic [CNT_W-1:0]       CONF_HOLDOFF,
  output logic                   FREEZE,
  output logic                   READ,
  output logic                   BUSY,
  output logic                   FRAME_START,
  output logic                   FRAME_DONE,
  output logic [HIT_CNT_W-1:0]   HIT_CNT,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tok_s;
  logic             cnt_zero;
  logic             freeze_nxt, read_nxt, frame_start_nxt, frame_done_nxt;
  logic             hit_inc, frame_inc;

  mono_readout_seq_sync #(.STAGES(2)) u_tok_sync (
    .CLK   (CLK),
    .RST_B (RST_B),
    .d     (TOKEN),
    .q     (tok_s)
  );

  assign cnt_zero = (cnt == '0);
  assign BUSY     = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt_zero ? cnt : cnt - 1'b1;
    freeze_nxt      = FREEZE;
    read_nxt        = READ;
    frame_start_nxt = 1'b0;
    frame_done_nxt  = 1'b0;
    hit_inc         = 1'b0;
    frame_inc       = 1'b0;

    case (state)
      IDLE: begin
        if (EN && tok_s) begin
          cnt_nxt         = CONF_FREEZE_START;
          frame_start_nxt = 1'b1;
          state_nxt       = DLY_FREEZE;
        end
      end
      DLY_FREEZE: begin
        if (cnt_zero) begin
          freeze_nxt = 1'b1;
          cnt_nxt    = CONF_READ_LOW;
          state_nxt  = READ_LO;
        end
      end
      READ_LO: begin
        // Token loss beats back-pressure; while near-full, cnt parks at zero and re-checks each cycle.
        if (cnt_zero) begin
          if (!tok_s) begin
            cnt_nxt   = CONF_FREEZE_STOP;
            state_nxt = UNFREEZE;
          end else if (!FIFO_NEAR_FULL) begin
            read_nxt  = 1'b1;
            cnt_nxt   = CONF_READ_HIGH;
            state_nxt = READ_HI;
          end
        end
      end
      READ_HI: begin
        if (cnt_zero) begin
          read_nxt  = 1'b0;
          hit_inc   = 1'b1;
          cnt_nxt   = CONF_READ_LOW;
          state_nxt = READ_LO;
        end
      end
      UNFREEZE: begin
        if (cnt_zero) begin
          freeze_nxt     = 1'b0;
          frame_done_nxt = 1'b1;
          frame_inc      = 1'b1;
          cnt_nxt        = CONF_HOLDOFF;
          state_nxt      = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cnt_zero) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state       <= IDLE;
      cnt         <= '0;
      FREEZE      <= 1'b0;
      READ        <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      FREEZE      <= freeze_nxt;
      READ        <= read_nxt;
      FRAME_START <= frame_start_nxt;
      FRAME_DONE  <= frame_done_nxt;
    end
  end

  // Status counters: a clear on the same edge as an increment leaves the counter at zero.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      HIT_CNT   <= '0;
      FRAME_CNT <= '0;
    end else begin
      if (CLR_CNT)                        HIT_CNT <= '0;
      else if (hit_inc && HIT_CNT != '1)  HIT_CNT <= HIT_CNT + 1'b1;

      if (CLR_CNT)        FRAME_CNT <= '0;
      else if (frame_inc) FRAME_CNT <= FRAME_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_mono_readout_seq.sv
// Randomised bench for mono_readout_seq: a timeline model predicts every output per cycle.
module tb_mono_readout_seq;
  import mono_pkg::*;

  localparam int CNT_W   = 8;
  localparam int HIT_W   = 4;
  localparam int FRAME_W = 16;
  localparam int HIT_MAX = (1 << HIT_W) - 1;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic en = 1'b0, token = 1'b0, fnf = 1'b0, clr_cnt = 1'b0;
  logic [CNT_W-1:0] c_fs, c_rh, c_rl, c_fst, c_ho;
  logic freeze, read, busy, frame_start, frame_done;
  logic [HIT_W-1:0]   hit_cnt;
  logic [FRAME_W-1:0] frame_cnt;

  int n_err = 0;
  int n_chk = 0;
  int exp_hit = 0;
  int exp_frame = 0;

  always #5 clk = ~clk;

  mono_readout_seq #(.CNT_W(CNT_W), .HIT_CNT_W(HIT_W), .FRAME_CNT_W(FRAME_W)) dut (
    .CLK               (clk),
    .RST_B             (rst_b),
    .EN                (en),
    .TOKEN             (token),
    .FIFO_NEAR_FULL    (fnf),
    .CLR_CNT           (clr_cnt),
    .CONF_FREEZE_START (c_fs),
    .CONF_READ_HIGH    (c_rh),
    .CONF_READ_LOW     (c_rl),
    .CONF_FREEZE_STOP  (c_fst),
    .CONF_HOLDOFF      (c_ho),
    .FREEZE            (freeze),
    .READ              (read),
    .BUSY              (busy),
    .FRAME_START       (frame_start),
    .FRAME_DONE        (frame_done),
    .HIT_CNT           (hit_cnt),
    .FRAME_CNT         (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_conf(input int fs, input int rh, input int rl, input int fst, input int ho);
    c_fs  = CNT_W'(fs);
    c_rh  = CNT_W'(rh);
    c_rl  = CNT_W'(rl);
    c_fst = CNT_W'(fst);
    c_ho  = CNT_W'(ho);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return read;
      1:       return frame_done;
      default: return busy;
    endcase
  endfunction

  // sel: 0=READ, 1=FRAME_DONE, 2=BUSY; an exhausted budget is reported as a failed check.
  task automatic wait_for(input int sel, input logic val, input int budget, input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (pick(sel) === val) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic clear_counts();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    exp_hit   = 0;
    exp_frame = 0;
    check("clr_counts", {hit_cnt, frame_cnt}, 32'd0);
  endtask

  // Timeline model. Edge 0 is the first edge that samples TOKEN=1; TOKEN is sampled high on
  // edges 0..len-1. The FSM sees tok_s two edges later, so it accepts on edge 2, and every
  // later decision point follows from the configured delays by plain arithmetic.
  task automatic run_frame(input string tag, input int fs, input int rh, input int rl,
                           input int fst, input int ho, input int len, input int en_drop);
    int f, p, d0, np, g, idle, off;
    logic rd;
    logic [4:0] exp_v;
    repeat (3) tick();
    f  = fs + 3;
    p  = rl + rh + 2;
    d0 = f + rl + 1;
    np = 0;
    while (d0 + np * p <= len + 1) np++;
    g    = d0 + np * p + fst + 1;
    idle = g + ho + 1;
    set_conf(fs, rh, rl, fst, ho);
    en    = 1'b1;
    token = 1'b1;
    for (int c = 0; c <= idle + 1; c++) begin
      tick();
      rd = 1'b0;
      if (c >= d0 && c < g) begin
        off = c - d0;
        rd  = ((off / p) < np) && ((off % p) <= rh);
      end
      exp_v = {(c >= f && c < g), rd, (c >= 2 && c < idle), (c == 2), (c == g)};
      check($sformatf("%s_wave_c%0d", tag, c), {freeze, read, busy, frame_start, frame_done},
            32'(exp_v));
      token = (c + 1 < len);
      en    = (c + 1 < en_drop);
    end
    en = 1'b1;
    exp_hit   = (exp_hit + np > HIT_MAX) ? HIT_MAX : exp_hit + np;
    exp_frame = exp_frame + 1;
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(exp_hit));
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frame));
  endtask

  initial begin
    bit seen, all_hi;

    set_conf(DEF_FREEZE_START, DEF_READ_HIGH, DEF_READ_LOW, DEF_FREEZE_STOP, DEF_HOLDOFF);
    #12;
    check("reset_out", {freeze, read, busy, frame_start, frame_done, hit_cnt, frame_cnt}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    check("reset_idle", 32'(busy), 32'd0);

    // Default frame: token held through three READ pulses.
    run_frame("dflt", DEF_FREEZE_START, DEF_READ_HIGH, DEF_READ_LOW, DEF_FREEZE_STOP,
              DEF_HOLDOFF, 22, 1000);

    // Back-pressure parks READ low while FREEZE stays high.
    set_conf(DEF_FREEZE_START, DEF_READ_HIGH, DEF_READ_LOW, DEF_FREEZE_STOP, DEF_HOLDOFF);
    en = 1'b1;
    token = 1'b1;
    wait_for(0, 1'b1, 40, "bp_rd_hi");
    wait_for(0, 1'b0, 40, "bp_rd_lo");
    fnf = 1'b1;
    seen = 1'b0;
    all_hi = 1'b1;
    repeat (20) begin
      tick();
      seen   |= read;
      all_hi &= freeze;
    end
    check("bp_no_read", 32'(seen), 32'd0);
    check("bp_freeze", 32'(all_hi), 32'd1);
    fnf = 1'b0;
    tick();
    check("bp_release_read", 32'(read), 32'd1);
    token = 1'b0;
    wait_for(2, 1'b0, 200, "bp_end");

    // EN gating, then EN dropped mid-frame.
    clear_counts();
    en = 1'b0;
    token = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      tick();
      seen |= busy;
    end
    check("en_gate_busy", 32'(seen), 32'd0);
    en = 1'b1;
    tick();
    check("en_frame_start", 32'(frame_start), 32'd1);
    en = 1'b0;
    repeat (15) tick();
    token = 1'b0;
    wait_for(2, 1'b0, 200, "en_end");
    check("en_frame_cnt", 32'(frame_cnt), 32'd1);
    en = 1'b1;

    // Clear on the same edge as a READ_HI completion.
    set_conf(2, 0, 3, 4, 5);
    token = 1'b1;
    wait_for(0, 1'b1, 40, "clr_rd_hi");
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_read_done", 32'(read), 32'd0);
    check("clr_wins", 32'(hit_cnt), 32'd0);
    token = 1'b0;
    wait_for(2, 1'b0, 200, "clr_end");
    check("clr_hit_stays", 32'(hit_cnt), 32'd0);

    // Token re-asserted during HOLDOFF starts the next frame only from IDLE.
    clear_counts();
    set_conf(DEF_FREEZE_START, DEF_READ_HIGH, DEF_READ_LOW, DEF_FREEZE_STOP, DEF_HOLDOFF);
    token = 1'b1;
    repeat (12) tick();
    token = 1'b0;
    wait_for(1, 1'b1, 80, "ho_done");
    token = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= frame_start;
    end
    check("ho_no_start", 32'(seen), 32'd0);
    check("ho_idle", 32'(busy), 32'd0);
    tick();
    check("ho_start", 32'(frame_start), 32'd1);
    repeat (10) tick();
    token = 1'b0;
    wait_for(2, 1'b0, 200, "ho_end");
    check("ho_frame_cnt", 32'(frame_cnt), 32'd2);

    // Saturation: 21 READ pulses into a 4-bit hit counter.
    clear_counts();
    run_frame("sat", DEF_FREEZE_START, DEF_READ_HIGH, DEF_READ_LOW, DEF_FREEZE_STOP,
              DEF_HOLDOFF, 130, 1000);
    check("sat_hit_max", 32'(hit_cnt), 32'(HIT_MAX));

    // Asynchronous reset in the middle of a READ pulse.
    set_conf(1, 5, 1, 1, 1);
    token = 1'b1;
    wait_for(0, 1'b1, 40, "rst_rd_hi");
    #2;
    rst_b = 1'b0;
    #1;
    check("rst_async", {freeze, read, busy, hit_cnt, frame_cnt}, 32'd0);
    token = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    exp_hit   = 0;
    exp_frame = 0;
    repeat (3) tick();
    check("rst_idle", 32'(busy), 32'd0);

    // Randomised frames.
    for (int k = 0; k < 25; k++) begin
      run_frame($sformatf("rnd%0d", k), $urandom_range(5, 0), $urandom_range(5, 0),
                $urandom_range(5, 0), $urandom_range(5, 0), $urandom_range(5, 0),
                $urandom_range(40, 1), $urandom_range(60, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
